nand_gate_sweep: RTL and testbench

Parametrised NAND-only logic-unit exerciser for the lab gate library. Builds seven bitwise gate functions on WIDTH-bit operands from two-input NAND primitives only. On a start pulse, steps a counter through every operand combination, one per clock, and streams registered results. It also folds the results into a 16-bit signature, so a bench or board checks a whole truth table with a single compare.

---
 rtl/nand_gate_sweep_pkg.sv | 24 ++
 rtl/nand_bitwise_gate.sv | 61 ++++++
 rtl/nand_gate_sweep.sv | 96 +++++++++
 tb/tb_nand_gate_sweep.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/nand_gate_sweep_pkg.sv
// Shared types for the NAND-only gate sweep: gate select codes, FSM states,
// and the signature width.
package nand_sweep_pkg;

    localparam int SIG_W = 16;

    typedef enum logic [2:0] {
        MODE_NOT  = 3'd0,
        MODE_NAND = 3'd1,
        MODE_AND  = 3'd2,
        MODE_OR   = 3'd3,
        MODE_NOR  = 3'd4,
        MODE_XOR  = 3'd5,
        MODE_XNOR = 3'd6,
        MODE_BUF  = 3'd7
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/nand_bitwise_gate.sv
// Combinational bitwise gate unit built only from two-input NAND primitives,
// including the 8:1 mode select tree.
module nand_bitwise_gate
    import nand_sweep_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  mode_e            mode,
    output wire  [WIDTH-1:0] y
);

    wire [2:0] s;
    wire [2:0] ns;
    assign s = mode;

    genvar i, j, k;

    for (k = 0; k < 3; k++) begin : g_sel
        nand u_ns (ns[k], s[k], s[k]);
    end

    for (i = 0; i < WIDTH; i++) begin : g_bit
        wire       na, nb, f_nand, f_and, f_or, f_nor, x1, x2, f_xor, f_xnor;
        wire [7:0] d;
        wire [3:0] l0;
        wire [1:0] l1;
        wire [6:0] t1, t0;

        nand u_na   (na,     a[i],   a[i]);
        nand u_nb   (nb,     b[i],   b[i]);
        nand u_nand (f_nand, a[i],   b[i]);
        nand u_and  (f_and,  f_nand, f_nand);
        nand u_or   (f_or,   na,     nb);
        nand u_nor  (f_nor,  f_or,   f_or);
        // Classic four-NAND XOR sharing the NAND term.
        nand u_x1   (x1,     a[i],   f_nand);
        nand u_x2   (x2,     b[i],   f_nand);
        nand u_xor  (f_xor,  x1,     x2);
        nand u_xnor (f_xnor, f_xor,  f_xor);

        assign d = {a[i], f_xnor, f_xor, f_nor, f_or, f_and, f_nand, na};

        // Each 2:1 stage: out = nand(nand(hi, sel), nand(lo, ~sel)).
        for (j = 0; j < 4; j++) begin : g_l0
            nand u_h (t1[j], d[2*j+1], s[0]);
            nand u_l (t0[j], d[2*j],   ns[0]);
            nand u_o (l0[j], t1[j],    t0[j]);
        end
        for (j = 0; j < 2; j++) begin : g_l1
            nand u_h (t1[4+j], l0[2*j+1], s[1]);
            nand u_l (t0[4+j], l0[2*j],   ns[1]);
            nand u_o (l1[j],   t1[4+j],   t0[4+j]);
        end
        nand u_h2 (t1[6], l1[1], s[2]);
        nand u_l2 (t0[6], l1[0], ns[2]);
        nand u_o2 (y[i],  t1[6], t0[6]);
    end

endmodule

// File: rtl/nand_gate_sweep.sv
// Sweeps every (a,b) operand pair through the NAND-only gate unit, streams
// registered samples and folds results into a rotating XOR signature.
module nand_gate_sweep
    import nand_sweep_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mode,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic [WIDTH-1:0] y_out,
    output logic             done,
    output logic [SIG_W-1:0] signature
);

    localparam int CW = 2 * WIDTH;

    state_e          state, state_nxt;
    mode_e           mode_q;
    logic [CW-1:0]   cnt;
    logic [WIDTH-1:0] a_cur, b_cur, y_cur;
    logic            last;

    assign a_cur = cnt[WIDTH-1:0];
    assign b_cur = cnt[CW-1:WIDTH];
    assign last  = (cnt == {CW{1'b1}});

    nand_bitwise_gate #(.WIDTH(WIDTH)) u_gate (
        .a    (a_cur),
        .b    (b_cur),
        .mode (mode_q),
        .y    (y_cur)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN:  if (last)  state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q    <= MODE_NOT;
            cnt       <= '0;
            busy      <= 1'b0;
            valid     <= 1'b0;
            done      <= 1'b0;
            a_out     <= '0;
            b_out     <= '0;
            y_out     <= '0;
            signature <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mode_q    <= mode_e'(mode);
                        cnt       <= '0;
                        signature <= '0;
                        busy      <= 1'b1;
                    end
                end
                ST_RUN: begin
                    a_out     <= a_cur;
                    b_out     <= b_cur;
                    y_out     <= y_cur;
                    valid     <= 1'b1;
                    signature <= {signature[SIG_W-2:0], signature[SIG_W-1]} ^ SIG_W'(y_cur);
                    // Hold at the final pattern so there is never a wrap sample.
                    if (!last) cnt <= cnt + 1'b1;
                end
                ST_DONE: begin
                    valid <= 1'b0;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nand_gate_sweep.sv
// Scoreboard bench: three sweep instances (WIDTH 1, 4, 8) exercised one at a
// time; expected samples are queued at start and popped on each valid.
module tb_nand_gate_sweep;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [2:0]  mode;
    int          sel;

    always #5 clk = ~clk;

    logic st1, st4, st8;
    assign st1 = start && (sel == 0);
    assign st4 = start && (sel == 1);
    assign st8 = start && (sel == 2);

    logic        bz1, vl1, dn1, bz4, vl4, dn4, bz8, vl8, dn8;
    logic [0:0]  a1, b1, y1;
    logic [3:0]  a4, b4, y4;
    logic [7:0]  a8, b8, y8;
    logic [15:0] s1, s4, s8;

    nand_gate_sweep #(.WIDTH(1)) u_w1 (.clk(clk), .rst(rst), .start(st1), .mode(mode),
        .busy(bz1), .valid(vl1), .a_out(a1), .b_out(b1), .y_out(y1), .done(dn1), .signature(s1));
    nand_gate_sweep #(.WIDTH(4)) u_w4 (.clk(clk), .rst(rst), .start(st4), .mode(mode),
        .busy(bz4), .valid(vl4), .a_out(a4), .b_out(b4), .y_out(y4), .done(dn4), .signature(s4));
    nand_gate_sweep #(.WIDTH(8)) u_w8 (.clk(clk), .rst(rst), .start(st8), .mode(mode),
        .busy(bz8), .valid(vl8), .a_out(a8), .b_out(b8), .y_out(y8), .done(dn8), .signature(s8));

    logic        v_busy, v_valid, v_done;
    logic [7:0]  v_a, v_b, v_y;
    logic [15:0] v_sig;

    always_comb begin
        v_busy = bz4; v_valid = vl4; v_done = dn4;
        v_a = {4'b0, a4}; v_b = {4'b0, b4}; v_y = {4'b0, y4}; v_sig = s4;
        if (sel == 0) begin
            v_busy = bz1; v_valid = vl1; v_done = dn1;
            v_a = {7'b0, a1}; v_b = {7'b0, b1}; v_y = {7'b0, y1}; v_sig = s1;
        end else if (sel == 2) begin
            v_busy = bz8; v_valid = vl8; v_done = dn8;
            v_a = a8; v_b = b8; v_y = y8; v_sig = s8;
        end
    end

    int checks = 0, fails = 0;
    int busy_cnt = 0, done_cnt = 0, nsamp = 0;
    logic [23:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int f(int m, int a, int b, int w);
        int mk, r;
        mk = (1 << w) - 1;
        case (m)
            0: r = ~a;
            1: r = ~(a & b);
            2: r = a & b;
            3: r = a | b;
            4: r = ~(a | b);
            5: r = a ^ b;
            6: r = ~(a ^ b);
            default: r = a;
        endcase
        return r & mk;
    endfunction

    task automatic push_exp(input int w, input int m, output logic [15:0] sig);
        int n, a, b, y, mk;
        n = 1 << (2 * w);
        mk = (1 << w) - 1;
        sig = '0;
        for (int c = 0; c < n; c++) begin
            a = c & mk;
            b = (c >> w) & mk;
            y = f(m, a, b, w);
            exp_q.push_back({8'(a), 8'(b), 8'(y)});
            sig = {sig[14:0], sig[15]} ^ 16'(y);
        end
    endtask

    always @(negedge clk) begin
        logic [23:0] e;
        if (v_busy) busy_cnt++;
        if (v_done) done_cnt++;
        if (v_valid) begin
            if (exp_q.size() == 0) chk("spurious_sample", {v_a, v_b, v_y}, 24'hxxxxxx);
            else begin
                e = exp_q.pop_front();
                chk("sample", {v_a, v_b, v_y}, e);
                nsamp++;
            end
        end
    end

    task automatic wait_done(input int n, input logic [15:0] es, input string tag);
        int  k = 0;
        bit  got = 1'b0;
        while (k < n + 8 && !got) begin
            @(negedge clk);
            k++;
            got = v_done;
        end
        #1;
        chk({tag, "_done_seen"}, 64'(got), 64'd1);
        if (got) begin
            chk({tag, "_sig"}, v_sig, es);
            chk({tag, "_busy_low"}, v_busy, 0);
            chk({tag, "_valid_low"}, v_valid, 0);
            chk({tag, "_busy_cycles"}, busy_cnt, n + 1);
            chk({tag, "_done_pulses"}, done_cnt, 1);
            chk({tag, "_queue_empty"}, exp_q.size(), 0);
        end
    endtask

    task automatic sweep(input int s, input int w, input int m, input bit meddle,
                         input string tag, output logic [15:0] es);
        sel = s;
        push_exp(w, m, es);
        busy_cnt = 0;
        done_cnt = 0;
        @(posedge clk); #1 start = 1'b1; mode = m[2:0];
        @(posedge clk); #1 start = 1'b0;
        if (meddle) begin
            repeat (10) @(posedge clk);
            #1 start = 1'b1; mode = ~mode;
            repeat (3) @(posedge clk);
            #1 start = 1'b0;
        end
        wait_done(1 << (2 * w), es, tag);
        @(negedge clk); #1;
        chk({tag, "_done_cleared"}, v_done, 0);
    endtask

    initial begin
        logic [15:0] es, es2;
        int k;
        rst = 1'b1; start = 1'b0; mode = 3'd0; sel = 1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            @(negedge clk); #1;
            chk("reset_state", {v_busy, v_valid, v_done, v_a, v_b, v_y, v_sig}, 0);
        end

        sweep(0, 1, 2, 1'b0, "w1_and", es);
        chk("w1_and_sig_const", v_sig, 16'h0001);
        sweep(0, 1, 5, 1'b0, "w1_xor", es);
        chk("w1_xor_sig_const", v_sig, 16'h0006);
        sweep(0, 1, 0, 1'b0, "w1_not", es);
        chk("w1_not_sig_const", v_sig, 16'h000A);

        for (int m = 0; m < 8; m++) sweep(1, 4, m, (m == 3), $sformatf("w4_m%0d", m), es);

        // Start held high across a sweep: next sweep must start at E(N+2).
        sel = 1;
        push_exp(4, 5, es);
        busy_cnt = 0; done_cnt = 0;
        @(posedge clk); #1 start = 1'b1; mode = 3'd5;
        wait_done(256, es, "hold1");
        push_exp(4, 5, es2);
        busy_cnt = 0; done_cnt = 0;
        @(negedge clk); #1;
        chk("hold_accept_busy", v_busy, 1);
        chk("hold_accept_valid", v_valid, 0);
        @(posedge clk); #1 start = 1'b0;
        wait_done(256, es2, "hold2");

        // Reset in the middle of a sweep discards it.
        sel = 1;
        push_exp(4, 6, es);
        nsamp = 0;
        @(posedge clk); #1 start = 1'b1; mode = 3'd6;
        @(posedge clk); #1 start = 1'b0;
        k = 0;
        while (nsamp < 100 && k < 400) begin @(negedge clk); #1; k++; end
        chk("rst_reached_100", nsamp, 100);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk); #1;
        chk("mid_rst_outputs", {v_busy, v_valid, v_done, v_a, v_b, v_y, v_sig}, 0);
        rst = 1'b0;
        sweep(1, 4, 6, 1'b0, "post_rst", es);

        sweep(2, 8, 3, 1'b0, "w8_or", es);
        repeat (3) begin @(negedge clk); #1; chk("w8_no_wrap", v_valid, 0); end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
